match_collector: RTL

Downstream consumer of the PE compare array in the string-matching datapath. Each accepted text character, it samples the per-PE match bits (`out_down` of PE 0..NUM_PE-1) and AND-reduces the active pattern length into a full-window match. It tracks the text position and buffers match start positions in a small FIFO. Positions leave on a valid/ready handshake to the result sink, with a running match count and a sticky overflow flag.

---
 rtl/string_match_pkg.sv | 24 ++
 rtl/match_fifo.sv | 59 +++++
 rtl/match_collector.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/string_match_pkg.sv
// Shared definitions for the string-matching datapath: collector FSM states,
// default array geometry and the PE ALU opcode encodings.
package string_match_pkg;

  localparam int NUM_PE_DEF = 8;
  localparam int POS_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } coll_state_e;

  // Per-PE compare operation selected by the controller.
  typedef enum logic [2:0] {
    ALU_NOP  = 3'd0,
    ALU_EQ   = 3'd1,
    ALU_NE   = 3'd2,
    ALU_WILD = 3'd3,
    ALU_LT   = 3'd4,
    ALU_GT   = 3'd5
  } ALU_op_e;

endpackage

// File: rtl/match_fifo.sv
// Synchronous position FIFO with flush; a push into a full FIFO succeeds only
// when a pop happens in the same cycle.
module match_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/match_collector.sv
// Collects full-window matches from the PE array and queues their start
// positions. Optional match counter: define MATCH_COLLECTOR_COUNT_EN.
module match_collector
  import string_match_pkg::*;
#(
  parameter int NUM_PE     = NUM_PE_DEF,
  parameter int POS_W      = POS_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [$clog2(NUM_PE+1)-1:0] pat_len,
  input  logic                        in_valid,
  input  logic                        in_last,
  input  logic [NUM_PE-1:0]           pe_match,
  output logic                        match_valid,
  input  logic                        match_ready,
  output logic [POS_W-1:0]            match_pos,
  output logic [POS_W-1:0]            match_count,
  output logic                        overflow,
  output logic                        busy,
  output logic                        done
);

  localparam int                LEN_W   = $clog2(NUM_PE+1);
  localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(NUM_PE);

  coll_state_e      state_q, state_d;
  logic [LEN_W-1:0] plen_q, plen_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             ovf_q, ovf_d;

  logic [NUM_PE-1:0] len_mask;
  logic [POS_W-1:0]  plen_ext;
  logic [POS_W-1:0]  start_pos;
  logic              accept;
  logic              window_all;
  logic              hit;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [POS_W-1:0]  fifo_head;

  assign accept = (state_q == ST_RUN) && in_valid && !start;

  always_comb begin
    len_mask = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      len_mask[k] = (LEN_W'(k) < plen_q);
    end
  end

  // Bits beyond the pattern length are forced true before the AND-reduce.
  assign window_all = &(pe_match | ~len_mask);
  assign plen_ext   = POS_W'(plen_q);
  assign start_pos  = pos_q - plen_ext + POS_W'(1);
  assign hit        = accept && (plen_q != '0) && window_all &&
                      (pos_q >= plen_ext - POS_W'(1));

  assign pop  = match_valid && match_ready;
  assign drop = hit && fifo_full && !pop;

  match_fifo #(
    .WIDTH (POS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .flush_i (start),
    .push_i  (hit),
    .pop_i   (pop),
    .data_i  (start_pos),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign match_valid = !fifo_empty;
  assign match_pos   = fifo_empty ? '0 : fifo_head;
  assign overflow    = ovf_q;
  assign busy        = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_RUN: begin
        if (accept && in_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      state_d = ST_RUN;
      done    = 1'b0;
    end
  end

  always_comb begin
    plen_d = plen_q;
    pos_d  = pos_q;
    ovf_d  = ovf_q;
    if (start) begin
      plen_d = (pat_len > MAX_LEN) ? MAX_LEN : pat_len;
      pos_d  = '0;
      ovf_d  = 1'b0;
    end else begin
      if (accept) pos_d = pos_q + POS_W'(1);
      if (drop)   ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      plen_q  <= '0;
      pos_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      plen_q  <= plen_d;
      pos_q   <= pos_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef MATCH_COLLECTOR_COUNT_EN
  logic [POS_W-1:0] count_q, count_d;

  // Counts every hit, including ones dropped on a full FIFO; saturates.
  always_comb begin
    count_d = count_q;
    if (start)                        count_d = '0;
    else if (hit && (count_q != '1)) count_d = count_q + POS_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign match_count = count_q;
`else
  assign match_count = '0;
`endif

endmodule
